seq_alu: RTL and testbench

- Parametrised, registered successor to the RAT combinational ALU.
- Executes the RAT 4-bit SEL op set on WIDTH-bit operands and holds C/Z in internal flag registers, so ADDC/SUBC/shift ops take carry-in from the stored C flag.
- Adds a multi-cycle unsigned shift-add multiply (SEL=15) behind a START/BUSY/DONE handshake.
- Sits between the register file and the control unit's flag logic.

---
 rtl/seq_alu.sv | 276 +++++++++++++++++++++++++++
 tb/tb_seq_alu.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: registered ALU executing the 4-bit SEL op set on WIDTH-bit
// operands. It keeps the carry (C) and zero (Z) flags in internal registers,
// so ADDC, SUBC, LSL and LSR take their carry-in from the stored C flag.
//
// Optional macro SEQ_ALU_MUL_EN:
//   defined   - SEL=15 starts a multi-cycle unsigned shift-add multiply,
//               using the BUSY/DONE handshake.
//   undefined - SEL=15 is a one-cycle NOP and BUSY is tied to 0.
//
// Ports:
//   CLK        rising-edge clock
//   RST_N      synchronous, active-low reset
//   START      request to execute SEL on A, B
//   SEL        operation select
//   A, B       operands (A is the destination register value)
//   FLAG_LD    load C/Z from FLAG_C_IN/FLAG_Z_IN (only while idle)
//   FLAG_C_IN  value loaded into C on FLAG_LD
//   FLAG_Z_IN  value loaded into Z on FLAG_LD
//   RESULT     registered result
//   WR_EN      pulses with DONE when RESULT must be written back
//   C, Z       registered flags
//   BUSY       multiply in progress
//   DONE       one-cycle pulse: RESULT/flags updated this cycle
module seq_alu #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic [3:0]       SEL,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             FLAG_LD,
  input  logic             FLAG_C_IN,
  input  logic             FLAG_Z_IN,
  output logic [WIDTH-1:0] RESULT,
  output logic             WR_EN,
  output logic             C,
  output logic             Z,
  output logic             BUSY,
  output logic             DONE
);

  localparam int unsigned EW = WIDTH + 1;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADDC = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_SUBC = 4'd3;
  localparam logic [3:0] OP_CMP  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_TEST = 4'd8;
  localparam logic [3:0] OP_LSL  = 4'd9;
  localparam logic [3:0] OP_LSR  = 4'd10;
  localparam logic [3:0] OP_ROL  = 4'd11;
  localparam logic [3:0] OP_ROR  = 4'd12;
  localparam logic [3:0] OP_ASR  = 4'd13;
  localparam logic [3:0] OP_MOV  = 4'd14;
  localparam logic [3:0] OP_MUL  = 4'd15;

  logic [WIDTH-1:0] result_q, result_d;
  logic             c_q, c_d;
  logic             z_q, z_d;
  logic             done_q, done_d;
  logic             wr_en_q, wr_en_d;
  logic             idle_c;

`ifdef SEQ_ALU_MUL_EN
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned PW    = 2 * WIDTH;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW-1:0]    acc_nxt;

  assign idle_c = (state_q == ST_IDLE);
`else
  assign idle_c = 1'b1;
`endif

  // Single-cycle op decode: computed value, carry, and which state it updates
  logic [WIDTH-1:0] op_val;
  logic             op_c;
  logic             op_upd_r;
  logic             op_upd_cz;
  logic [EW-1:0]    ext;

  always_comb begin
    op_val    = '0;
    op_c      = 1'b0;
    op_upd_r  = 1'b1;
    op_upd_cz = 1'b1;
    ext       = '0;
    case (SEL)
      OP_ADD: begin
        ext    = {1'b0, A} + {1'b0, B};
        op_val = ext[WIDTH-1:0];
        op_c   = ext[WIDTH];
      end
      OP_ADDC: begin
        ext    = {1'b0, A} + {1'b0, B} + EW'(c_q);
        op_val = ext[WIDTH-1:0];
        op_c   = ext[WIDTH];
      end
      OP_SUB: begin
        ext    = {1'b0, A} - {1'b0, B};
        op_val = ext[WIDTH-1:0];
        op_c   = ext[WIDTH];
      end
      OP_SUBC: begin
        ext    = {1'b0, A} - {1'b0, B} - EW'(c_q);
        op_val = ext[WIDTH-1:0];
        op_c   = ext[WIDTH];
      end
      OP_CMP: begin
        ext      = {1'b0, A} - {1'b0, B};
        op_val   = ext[WIDTH-1:0];
        op_c     = ext[WIDTH];
        op_upd_r = 1'b0;
      end
      OP_AND:  op_val = A & B;
      OP_OR:   op_val = A | B;
      OP_XOR:  op_val = A ^ B;
      OP_TEST: begin
        op_val   = A & B;
        op_upd_r = 1'b0;
      end
      OP_LSL: begin
        op_val = {A[WIDTH-2:0], c_q};
        op_c   = A[WIDTH-1];
      end
      OP_LSR: begin
        op_val = {c_q, A[WIDTH-1:1]};
        op_c   = A[0];
      end
      OP_ROL: begin
        op_val = {A[WIDTH-2:0], A[WIDTH-1]};
        op_c   = A[WIDTH-1];
      end
      OP_ROR: begin
        op_val = {A[0], A[WIDTH-1:1]};
        op_c   = A[0];
      end
      OP_ASR: begin
        op_val = {A[WIDTH-1], A[WIDTH-1:1]};
        op_c   = A[0];
      end
      OP_MOV: begin
        op_val    = B;
        op_upd_cz = 1'b0;
      end
      default: begin
        // SEL=15 outside the multiplier: NOP leaving RESULT and flags alone
        op_upd_r  = 1'b0;
        op_upd_cz = 1'b0;
      end
    endcase
  end

  // Next-state logic: op acceptance, flag restore and multiply iterations
  always_comb begin
    result_d = result_q;
    c_d      = c_q;
    z_d      = z_q;
    done_d   = 1'b0;
    wr_en_d  = 1'b0;
`ifdef SEQ_ALU_MUL_EN
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    acc_nxt  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
`endif

    if (idle_c) begin
      // Flag restore takes priority over a simultaneous START
      if (FLAG_LD) begin
        c_d = FLAG_C_IN;
        z_d = FLAG_Z_IN;
      end else if (START) begin
`ifdef SEQ_ALU_MUL_EN
        if (SEL == OP_MUL) begin
          acc_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, A};
          mplier_d = B;
          cnt_d    = CNT_W'(WIDTH);
          state_d  = ST_MUL;
        end else
`endif
        begin
          if (op_upd_r) begin
            result_d = op_val;
          end
          if (op_upd_cz) begin
            c_d = op_c;
            z_d = (op_val == '0);
          end
          done_d  = 1'b1;
          wr_en_d = op_upd_r;
        end
      end
    end

`ifdef SEQ_ALU_MUL_EN
    if (state_q == ST_MUL) begin
      acc_d    = acc_nxt;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CNT_W'(1);
      // Last iteration publishes the product directly from acc_nxt
      if (cnt_q == CNT_W'(1)) begin
        result_d = acc_nxt[WIDTH-1:0];
        c_d      = |acc_nxt[PW-1:WIDTH];
        z_d      = (acc_nxt[WIDTH-1:0] == '0);
        done_d   = 1'b1;
        wr_en_d  = 1'b1;
        state_d  = ST_IDLE;
      end
    end
`endif
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      result_q <= '0;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      done_q   <= 1'b0;
      wr_en_q  <= 1'b0;
`ifdef SEQ_ALU_MUL_EN
      state_q  <= ST_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
`endif
    end else begin
      result_q <= result_d;
      c_q      <= c_d;
      z_q      <= z_d;
      done_q   <= done_d;
      wr_en_q  <= wr_en_d;
`ifdef SEQ_ALU_MUL_EN
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign RESULT = result_q;
  assign C      = c_q;
  assign Z      = z_q;
  assign DONE   = done_q;
  assign WR_EN  = wr_en_q;
`ifdef SEQ_ALU_MUL_EN
  assign BUSY   = (state_q == ST_MUL);
`else
  assign BUSY   = 1'b0;
`endif

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: self-checking bench for seq_alu at WIDTH=8. A table of
// back-to-back single-cycle ops is checked first, followed by hand-written
// sequences for flag restore, SEL=15 (multiply or NOP, depending on
// SEQ_ALU_MUL_EN) and reset.
module tb_seq_alu;

  localparam int unsigned W = 8;

  logic         CLK;
  logic         RST_N;
  logic         START;
  logic [3:0]   SEL;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         FLAG_LD;
  logic         FLAG_C_IN;
  logic         FLAG_Z_IN;
  logic [W-1:0] RESULT;
  logic         WR_EN;
  logic         C;
  logic         Z;
  logic         BUSY;
  logic         DONE;

  int checks   = 0;
  int failures = 0;

  seq_alu #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .START     (START),
    .SEL       (SEL),
    .A         (A),
    .B         (B),
    .FLAG_LD   (FLAG_LD),
    .FLAG_C_IN (FLAG_C_IN),
    .FLAG_Z_IN (FLAG_Z_IN),
    .RESULT    (RESULT),
    .WR_EN     (WR_EN),
    .C         (C),
    .Z         (Z),
    .BUSY      (BUSY),
    .DONE      (DONE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]   sel;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         c;
    logic         z;
    logic         wr;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_state(input string nm, input logic [W-1:0] res, input logic c,
                           input logic z, input logic done, input logic wr, input logic busy);
    chk({nm, " RESULT"}, 32'(RESULT), 32'(res));
    chk({nm, " C"},      32'(C),      32'(c));
    chk({nm, " Z"},      32'(Z),      32'(z));
    chk({nm, " DONE"},   32'(DONE),   32'(done));
    chk({nm, " WR_EN"},  32'(WR_EN),  32'(wr));
    chk({nm, " BUSY"},   32'(BUSY),   32'(busy));
  endtask

  initial begin
    int n;
    int seen_done;

    // Chained vectors: each expected C/Z assumes the flags left by the row above
    vecs[0]  = '{4'd0,  8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1'b1}; // ADD overflow
    vecs[1]  = '{4'd1,  8'h10, 8'h20, 8'h31, 1'b0, 1'b0, 1'b1}; // ADDC cin=1
    vecs[2]  = '{4'd2,  8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b1}; // SUB borrow
    vecs[3]  = '{4'd3,  8'h00, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b1}; // SUBC cin=1
    vecs[4]  = '{4'd14, 8'h00, 8'h31, 8'h31, 1'b1, 1'b0, 1'b1}; // MOV keeps flags
    vecs[5]  = '{4'd4,  8'h05, 8'h05, 8'h31, 1'b0, 1'b1, 1'b0}; // CMP equal
    vecs[6]  = '{4'd12, 8'h01, 8'h00, 8'h80, 1'b1, 1'b0, 1'b1}; // ROR
    vecs[7]  = '{4'd9,  8'h81, 8'h00, 8'h03, 1'b1, 1'b0, 1'b1}; // LSL cin=1
    vecs[8]  = '{4'd10, 8'h02, 8'h00, 8'h81, 1'b0, 1'b0, 1'b1}; // LSR cin=1
    vecs[9]  = '{4'd10, 8'h01, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1}; // LSR cin=0
    vecs[10] = '{4'd11, 8'h80, 8'h00, 8'h01, 1'b1, 1'b0, 1'b1}; // ROL
    vecs[11] = '{4'd13, 8'h80, 8'h00, 8'hC0, 1'b0, 1'b0, 1'b1}; // ASR
    vecs[12] = '{4'd5,  8'hF0, 8'h0F, 8'h00, 1'b0, 1'b1, 1'b1}; // AND
    vecs[13] = '{4'd7,  8'hAA, 8'hAA, 8'h00, 1'b0, 1'b1, 1'b1}; // XOR
    vecs[14] = '{4'd6,  8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0, 1'b1}; // OR
    vecs[15] = '{4'd8,  8'h0F, 8'hF0, 8'hFF, 1'b0, 1'b1, 1'b0}; // TEST zero
    vecs[16] = '{4'd8,  8'h0F, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0}; // TEST nonzero
    vecs[17] = '{4'd2,  8'h05, 8'h03, 8'h02, 1'b0, 1'b0, 1'b1}; // SUB no borrow
    vecs[18] = '{4'd4,  8'h03, 8'h05, 8'h02, 1'b1, 1'b0, 1'b0}; // CMP borrow
    vecs[19] = '{4'd1,  8'h01, 8'h01, 8'h03, 1'b0, 1'b0, 1'b1}; // ADDC cin=1
    vecs[20] = '{4'd14, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1}; // MOV 0, Z stays 0
    vecs[21] = '{4'd0,  8'h80, 8'h80, 8'h00, 1'b1, 1'b1, 1'b1}; // ADD carry
    vecs[22] = '{4'd5,  8'hFF, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1}; // AND -> C=0

    RST_N = 1'b0; START = 1'b0; SEL = 4'd0; A = '0; B = '0;
    FLAG_LD = 1'b0; FLAG_C_IN = 1'b0; FLAG_Z_IN = 1'b0;
    repeat (2) @(negedge CLK);
    chk_state("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    RST_N = 1'b1;
    @(negedge CLK);

    // Back-to-back single-cycle ops, START held high across all rows
    for (int i = 0; i < NV; i++) begin
      START = 1'b1; SEL = vecs[i].sel; A = vecs[i].a; B = vecs[i].b;
      @(negedge CLK);
      chk_state($sformatf("vec%0d", i), vecs[i].res, vecs[i].c, vecs[i].z,
                1'b1, vecs[i].wr, 1'b0);
    end
    START = 1'b0;
    @(negedge CLK);
    chk_state("idle", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // FLAG_LD wins over a simultaneous START
    FLAG_LD = 1'b1; FLAG_C_IN = 1'b1; FLAG_Z_IN = 1'b0;
    START = 1'b1; SEL = 4'd0; A = 8'h01; B = 8'h01;
    @(negedge CLK);
    FLAG_LD = 1'b0; START = 1'b0;
    chk_state("flag_ld", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef SEQ_ALU_MUL_EN
    // MUL 0x10*0x20 = 0x200; extra STARTs and FLAG_LD while busy are ignored
    START = 1'b1; SEL = 4'd15; A = 8'h10; B = 8'h20;
    @(negedge CLK);
    chk_state("mul1 c1", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    SEL = 4'd0; A = 8'h01; B = 8'h01;
    FLAG_LD = 1'b1; FLAG_C_IN = 1'b0; FLAG_Z_IN = 1'b1;
    for (int j = 2; j <= 8; j++) begin
      @(negedge CLK);
      chk_state($sformatf("mul1 c%0d", j), 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    START = 1'b0; FLAG_LD = 1'b0;
    @(negedge CLK);
    chk_state("mul1 done", 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    @(negedge CLK);
    chk_state("mul1 after", 8'h00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // MUL 0x0F*0x0F = 0xE1, with a bounded wait for DONE
    START = 1'b1; SEL = 4'd15; A = 8'h0F; B = 8'h0F;
    @(negedge CLK);
    START = 1'b0;
    n = 1;
    while (!DONE && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk("mul2 latency", 32'(n), 32'd9);
    chk_state("mul2 done", 8'hE1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Reset in the 4th busy cycle aborts the multiply with no DONE
    START = 1'b1; SEL = 4'd15; A = 8'h03; B = 8'h05;
    @(negedge CLK);
    START = 1'b0;
    repeat (3) @(negedge CLK);
    chk("mul3 busy before reset", 32'(BUSY), 32'd1);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    chk_state("mul3 reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    seen_done = 0;
    for (int j = 0; j < 12; j++) begin
      @(negedge CLK);
      if (DONE || BUSY) seen_done++;
    end
    chk("mul3 no done after reset", 32'(seen_done), 32'd0);
`else
    // SEL=15 without the multiplier: one-cycle NOP
    START = 1'b1; SEL = 4'd15; A = 8'h12; B = 8'h34;
    @(negedge CLK);
    START = 1'b0;
    chk_state("nop", 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge CLK);
    chk_state("nop after", 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Give RESULT a nonzero value, then reset with START also high
    START = 1'b1; SEL = 4'd6; A = 8'h5A; B = 8'h00;
    @(negedge CLK);
    chk_state("or5a", 8'h5A, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    SEL = 4'd0; A = 8'hFF; B = 8'h01;
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1; START = 1'b0;
    chk_state("reset2", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
